// File: rtl/axis_chunk_scheduler_pkg.sv
// rtl/axis_chunk_scheduler_pkg.sv - shared types, defaults and helpers for the chunk scheduler
package axis_chunk_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DATA  = 2'd3
  } sched_state_t;

  localparam int BOUNDARY_BYTES_DEF = 4096;

  // ceil(log2(value)); constant-foldable so it can size localparams
  function automatic int clog2_int(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_chunk_scheduler_if.sv
// rtl/axis_chunk_scheduler_if.sv - descriptor, crossbar address and data stream bundle
interface axis_chunk_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 4
);

  logic                  s_cmd_valid;
  logic                  s_cmd_ready;
  logic                  s_cmd_rnw;
  logic [ADDR_WIDTH-1:0] s_cmd_addr;
  logic [ADDR_WIDTH-1:0] s_cmd_bytes;

  logic                  m_avalid;
  logic                  m_aready;
  logic                  m_arnw;
  logic [ADDR_WIDTH-1:0] m_aaddr;
  logic [ADDR_WIDTH-1:0] m_abytes;

  logic                  s_wvalid;
  logic                  s_wready;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [STRB_WIDTH-1:0] s_wstrb;
  logic                  s_wlast;

  logic                  m_wvalid;
  logic                  m_wready;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_WIDTH-1:0] m_wstrb;
  logic                  m_wlast;

  logic                  m_rvalid;
  logic                  m_rready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_rlast;

  logic                  s_rvalid;
  logic                  s_rready;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic                  s_rlast;

  logic                  busy;
  logic                  done;
  logic                  err;

  // scheduler view
  modport slave (
    input  s_cmd_valid, s_cmd_rnw, s_cmd_addr, s_cmd_bytes,
    output s_cmd_ready,
    output m_avalid, m_arnw, m_aaddr, m_abytes,
    input  m_aready,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast,
    output s_wready,
    output m_wvalid, m_wdata, m_wstrb, m_wlast,
    input  m_wready,
    input  m_rvalid, m_rdata, m_rlast,
    output m_rready,
    output s_rvalid, s_rdata, s_rlast,
    input  s_rready,
    output busy, done, err
  );

  // requester plus crossbar view
  modport master (
    output s_cmd_valid, s_cmd_rnw, s_cmd_addr, s_cmd_bytes,
    input  s_cmd_ready,
    input  m_avalid, m_arnw, m_aaddr, m_abytes,
    output m_aready,
    output s_wvalid, s_wdata, s_wstrb, s_wlast,
    input  s_wready,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast,
    output m_wready,
    output m_rvalid, m_rdata, m_rlast,
    input  m_rready,
    input  s_rvalid, s_rdata, s_rlast,
    output s_rready,
    input  busy, done, err
  );

endinterface

// File: rtl/axis_chunk_scheduler_size_calc.sv
// rtl/axis_chunk_scheduler_size_calc.sv - min-of-three chunk sizer
module axis_chunk_size_calc
  import axis_chunk_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int STRB_WIDTH      = 4,
  parameter int MAX_CHUNK_BYTES = 256,
  parameter int BOUNDARY_BYTES  = BOUNDARY_BYTES_DEF,
  parameter int BEAT_W          = 7
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] remaining,
  output logic [ADDR_WIDTH-1:0] chunk,
  output logic [BEAT_W-1:0]     beats
);

  localparam logic [ADDR_WIDTH-1:0] MAX_C    = ADDR_WIDTH'(MAX_CHUNK_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BOUND    = ADDR_WIDTH'(BOUNDARY_BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(BOUNDARY_BYTES - 1);
  localparam int                    SHIFT    = clog2_int(STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] to_bound;
  logic [ADDR_WIDTH-1:0] c_min;

  // smallest of remaining bytes, max chunk and bytes left before the boundary
  always_comb begin
    to_bound = BOUND - (addr & OFS_MASK);
    c_min    = remaining;
    if (MAX_C < c_min) begin
      c_min = MAX_C;
    end
    if (to_bound < c_min) begin
      c_min = to_bound;
    end
    chunk = c_min;
    beats = BEAT_W'(c_min >> SHIFT);
  end

endmodule

// File: rtl/axis_chunk_scheduler.sv
// rtl/axis_chunk_scheduler.sv - splits descriptors into boundary-safe chunks and gates streams
module axis_chunk_scheduler
  import axis_chunk_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int STRB_WIDTH      = 4,
  parameter int MAX_CHUNK_BYTES = 256,
  parameter int BOUNDARY_BYTES  = BOUNDARY_BYTES_DEF
) (
  input  logic                  aclk,
  input  logic                  resetn,
  axis_chunk_scheduler_if.slave bus
);

  localparam int BEATS_MAX = MAX_CHUNK_BYTES / STRB_WIDTH;
  localparam int BEAT_W    = clog2_int(BEATS_MAX) + 1;

  sched_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] rem_q;
  logic [ADDR_WIDTH-1:0] chunk_q;
  logic [BEAT_W-1:0]     beats_q;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic                  rnw_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] calc_chunk;
  logic [BEAT_W-1:0]     calc_beats;

  logic in_data;
  logic cmd_fire;
  logic beat_fire;
  logic chunk_final;
  logic last_chunk;
  logic desc_final;
  logic err_event;

  axis_chunk_size_calc #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .STRB_WIDTH      (STRB_WIDTH),
    .MAX_CHUNK_BYTES (MAX_CHUNK_BYTES),
    .BOUNDARY_BYTES  (BOUNDARY_BYTES),
    .BEAT_W          (BEAT_W)
  ) u_size_calc (
    .addr      (addr_q),
    .remaining (rem_q),
    .chunk     (calc_chunk),
    .beats     (calc_beats)
  );

  // a beat is forwarded only in DATA and only on the descriptor's direction
  assign in_data     = (state_q == ST_DATA);
  assign cmd_fire    = bus.s_cmd_valid && (state_q == ST_IDLE);
  assign beat_fire   = in_data && (rnw_q ? (bus.s_wvalid && bus.m_wready)
                                         : (bus.m_rvalid && bus.s_rready));
  assign chunk_final = (beat_cnt_q == beats_q - BEAT_W'(1));
  assign last_chunk  = (rem_q == chunk_q);
  assign desc_final  = chunk_final && last_chunk;
  assign err_event   = rnw_q ? (bus.s_wlast != desc_final) : (bus.m_rlast != chunk_final);

  // state register
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire && (bus.s_cmd_bytes != '0)) begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (bus.m_aready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_fire && chunk_final) begin
          state_d = last_chunk ? ST_IDLE : ST_CALC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // descriptor progress, beat counter and status flags
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      addr_q     <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      rnw_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            addr_q <= bus.s_cmd_addr;
            rem_q  <= bus.s_cmd_bytes;
            rnw_q  <= bus.s_cmd_rnw;
            busy_q <= (bus.s_cmd_bytes != '0);
            done_q <= (bus.s_cmd_bytes == '0);
          end
        end
        ST_CALC: begin
          chunk_q    <= calc_chunk;
          beats_q    <= calc_beats;
          beat_cnt_q <= '0;
        end
        ST_DATA: begin
          if (beat_fire) begin
            if (chunk_final) begin
              beat_cnt_q <= '0;
              addr_q     <= addr_q + chunk_q;
              rem_q      <= rem_q - chunk_q;
              if (last_chunk) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (beat_fire && err_event) begin
        err_q <= 1'b1;
      end
    end
  end

  // address request, stream gating and regenerated last flags
  always_comb begin
    bus.s_cmd_ready = (state_q == ST_IDLE);
    bus.m_avalid    = (state_q == ST_ISSUE);
    bus.m_arnw      = rnw_q;
    bus.m_aaddr     = addr_q;
    bus.m_abytes    = chunk_q;

    bus.m_wvalid    = bus.s_wvalid && in_data && rnw_q;
    bus.s_wready    = bus.m_wready && in_data && rnw_q;
    bus.m_wdata     = DATA_WIDTH'(bus.s_wdata);
    bus.m_wstrb     = bus.s_wstrb;
    bus.m_wlast     = in_data && rnw_q && chunk_final;

    bus.s_rvalid    = bus.m_rvalid && in_data && !rnw_q;
    bus.m_rready    = bus.s_rready && in_data && !rnw_q;
    bus.s_rdata     = DATA_WIDTH'(bus.m_rdata);
    bus.s_rlast     = in_data && !rnw_q && desc_final;

    bus.busy        = busy_q;
    bus.done        = done_q;
    bus.err         = err_q;
  end

endmodule

// File: tb/tb_axis_chunk_scheduler.sv
// tb/tb_axis_chunk_scheduler.sv - randomized self-checking bench with descriptor split model
module tb_axis_chunk_scheduler;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int MAXC = 256;
  localparam int BND  = 4096;

  logic aclk = 1'b0;
  logic resetn = 1'b0;

  always #5 aclk = ~aclk;

  axis_chunk_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

  axis_chunk_scheduler #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .STRB_WIDTH      (SW),
    .MAX_CHUNK_BYTES (MAXC),
    .BOUNDARY_BYTES  (BND)
  ) dut (
    .aclk   (aclk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.s_cmd_valid = 1'b0;
    bus.s_cmd_rnw   = 1'b0;
    bus.s_cmd_addr  = '0;
    bus.s_cmd_bytes = '0;
    bus.m_aready    = 1'b0;
    bus.s_wvalid    = 1'b0;
    bus.s_wdata     = '0;
    bus.s_wstrb     = '0;
    bus.s_wlast     = 1'b0;
    bus.m_wready    = 1'b0;
    bus.m_rvalid    = 1'b0;
    bus.m_rdata     = '0;
    bus.m_rlast     = 1'b0;
    bus.s_rready    = 1'b0;
  endtask

  // chunk list: repeatedly take the largest piece allowed by the three limits
  task automatic plan(input logic [31:0] addr, input logic [31:0] bytes);
    longint a;
    longint r;
    longint c;
    longint room;
    exp_a.delete();
    exp_b.delete();
    a = addr;
    r = bytes;
    while (r > 0) begin
      room = BND - (a % BND);
      c = r;
      if (c > MAXC) c = MAXC;
      if (c > room) c = room;
      exp_a.push_back(a[31:0]);
      exp_b.push_back(c[31:0]);
      a = (a + c) % 64'h1_0000_0000;
      r = r - c;
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] base, input int idx);
    logic [31:0] k;
    k = idx;
    return base ^ (k * 32'h9E37_79B1);
  endfunction

  task automatic run_desc(input bit rnw, input logic [31:0] addr, input logic [31:0] bytes,
                          input int wlast_beat, input int aready_hold, input int abort_at,
                          input bit exp_err);
    int total;
    int idx;
    int chunk_left;
    int hold;
    int cyc;
    bit seen_done;
    bit aborted;
    bit s_fire;
    bit m_fire;
    logic [31:0] base;
    total = int'(bytes / SW);
    idx = 0;
    chunk_left = 0;
    hold = aready_hold;
    cyc = 0;
    seen_done = 1'b0;
    aborted = 1'b0;
    base = $urandom;
    plan(addr, bytes);

    @(negedge aclk);
    bus.s_cmd_valid = 1'b1;
    bus.s_cmd_rnw   = rnw;
    bus.s_cmd_addr  = addr;
    bus.s_cmd_bytes = bytes;
    #1;
    check_eq("cmd_ready", bus.s_cmd_ready, 1);
    @(posedge aclk);

    while (!seen_done && !aborted && cyc < 20000) begin
      @(negedge aclk);
      cyc++;
      bus.s_cmd_valid = 1'b0;
      bus.m_aready = (hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (bus.m_avalid && hold > 0) hold--;
      bus.s_wvalid = rnw && (idx < total) && ($urandom_range(0, 3) != 0);
      bus.s_wdata  = pat(base, idx);
      bus.s_wstrb  = 4'(idx) | 4'h1;
      bus.s_wlast  = (idx + 1 == wlast_beat);
      bus.m_wready = ($urandom_range(0, 3) != 0);
      bus.m_rvalid = !rnw && (chunk_left > 0) && ($urandom_range(0, 3) != 0);
      bus.m_rdata  = pat(base, idx);
      bus.m_rlast  = (chunk_left == 1);
      bus.s_rready = ($urandom_range(0, 3) != 0);
      #1;
      if (cyc == 1) check_eq("busy_on_accept", bus.busy, 1);

      if (rnw) begin
        s_fire = bus.s_wvalid && bus.s_wready;
        m_fire = bus.m_wvalid && bus.m_wready;
      end else begin
        s_fire = bus.s_rvalid && bus.s_rready;
        m_fire = bus.m_rvalid && bus.m_rready;
      end
      if (s_fire || m_fire) begin
        check_eq("fire_match", m_fire, s_fire);
        if (chunk_left == 0) check_eq("beat_outside_chunk", 1, 0);
        if (rnw) begin
          check_eq("wdata", bus.m_wdata, pat(base, idx));
          check_eq("wstrb", bus.m_wstrb, 4'(idx) | 4'h1);
          check_eq("wlast", bus.m_wlast, chunk_left == 1);
        end else begin
          check_eq("rdata", bus.s_rdata, pat(base, idx));
          check_eq("rlast", bus.s_rlast, idx + 1 == total);
        end
        idx++;
        if (chunk_left > 0) chunk_left--;
        if (abort_at > 0 && idx == abort_at) aborted = 1'b1;
      end

      if (bus.m_avalid) begin
        if (exp_a.size() == 0 || chunk_left != 0) begin
          check_eq("extra_request", 1, 0);
        end else begin
          check_eq("req_addr", bus.m_aaddr, exp_a[0]);
          check_eq("req_bytes", bus.m_abytes, exp_b[0]);
          check_eq("req_rnw", bus.m_arnw, rnw);
          if (bus.m_aready) begin
            chunk_left = int'(exp_b[0] / SW);
            void'(exp_a.pop_front());
            void'(exp_b.pop_front());
          end
        end
      end

      if (bus.done) begin
        seen_done = 1'b1;
        check_eq("done_beats", idx, total);
        check_eq("done_chunks_left", exp_a.size(), 0);
        check_eq("busy_after_done", bus.busy, 0);
        check_eq("ready_with_done", bus.s_cmd_ready, 1);
        check_eq("err_at_done", bus.err, exp_err);
      end
    end

    if (aborted) begin
      resetn = 1'b0;
      @(posedge aclk);
      #1;
      check_eq("abort_avalid", bus.m_avalid, 0);
      check_eq("abort_busy", bus.busy, 0);
      check_eq("abort_cmd_ready", bus.s_cmd_ready, 1);
      check_eq("abort_done", bus.done, 0);
      check_eq("abort_err", bus.err, 0);
      check_eq("abort_wvalid", bus.m_wvalid, 0);
      @(negedge aclk);
      resetn = 1'b1;
      idle_inputs();
    end else begin
      if (!seen_done) check_eq("timeout", 0, 1);
      @(negedge aclk);
      idle_inputs();
      #1;
      check_eq("done_one_cycle", bus.done, 0);
    end
  endtask

  task automatic run_zero(input bit rnw, input logic [31:0] addr);
    @(negedge aclk);
    bus.s_cmd_valid = 1'b1;
    bus.s_cmd_rnw   = rnw;
    bus.s_cmd_addr  = addr;
    bus.s_cmd_bytes = '0;
    #1;
    check_eq("zero_cmd_ready", bus.s_cmd_ready, 1);
    @(negedge aclk);
    idle_inputs();
    #1;
    check_eq("zero_done", bus.done, 1);
    check_eq("zero_avalid", bus.m_avalid, 0);
    check_eq("zero_busy", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1;
      check_eq("zero_no_request", bus.m_avalid, 0);
      check_eq("zero_done_clear", bus.done, 0);
    end
  endtask

  initial begin
    logic [31:0] r_addr;
    logic [31:0] r_bytes;
    bit          r_rnw;
    idle_inputs();
    resetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_eq("reset_avalid", bus.m_avalid, 0);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done", bus.done, 0);
    check_eq("reset_err", bus.err, 0);
    check_eq("reset_cmd_ready", bus.s_cmd_ready, 1);
    @(negedge aclk);
    resetn = 1'b1;

    run_desc(1'b0, 32'h0000_1000, 32'd64, 0, 0, 0, 1'b0);
    run_desc(1'b1, 32'h0000_0000, 32'd600, 150, 0, 0, 1'b0);
    run_desc(1'b0, 32'h0000_0FC0, 32'd128, 0, 10, 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      r_rnw   = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 3) * BND + $urandom_range(0, 1023) * SW);
      r_bytes = 32'($urandom_range(1, 300) * SW);
      run_desc(r_rnw, r_addr, r_bytes, int'(r_bytes / SW), $urandom_range(0, 5), 0, 1'b0);
    end

    run_zero(1'b1, 32'h0000_0400);

    run_desc(1'b1, 32'h0000_2000, 32'd32, 4, 0, 0, 1'b1);
    repeat (2) @(negedge aclk);
    #1;
    check_eq("err_sticky", bus.err, 1);

    run_desc(1'b1, 32'h0000_0100, 32'd600, 150, 0, 20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
